muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execute unit, parametrised in operand width. Sits beside the single-cycle ALU in the execute stage: the control unit issues an M-extension operation with a one-cycle `start`, stalls the pipeline on `busy`, and writes `result` back when `done` pulses. Shift-add multiply and restoring divide, one result bit per cycle.

---
 rtl/muldiv_unit.sv | 201 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execute unit.
// Shift-add multiply and restoring divide, one result bit per cycle.
// Operands are held as magnitudes plus sign flags; signs are applied in the
// final step. Divide-by-zero and signed overflow finish in one cycle.
// Optional feature macro: MULDIV_DIV_EN enables the divide datapath. When it
// is undefined, divide ops finish in one cycle with illegal=1 and result=0.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      f3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

`ifdef MULDIV_DIV_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_FIN = 2'd2, S_DIV = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_FIN = 2'd2} state_t;
`endif

  state_t              state;
  logic [1:0]          op;      // f3[1:0]; f3[2] is implied by the state
  logic                neg_a;
  logic                neg_b;
  logic [2*XLEN-1:0]   acc;     // product, or {remainder, dividend/quotient}
  logic [2*XLEN-1:0]   mcand;   // multiplicand, shifted left each iteration
  logic [XLEN-1:0]     opb;     // multiplier (shifted right) or divisor
  logic [CNT_W-1:0]    cnt;

  // Issue-time operand conditioning
  logic                a_signed;
  logic                b_signed;
  logic                in_neg_a;
  logic                in_neg_b;
  logic [XLEN-1:0]     abs_a;
  logic [XLEN-1:0]     abs_b;

  // Multiply step and final value
  logic [2*XLEN-1:0]   mul_acc_next;
  logic [2*XLEN-1:0]   mul_prod;
  logic [XLEN-1:0]     mul_res;

`ifdef MULDIV_DIV_EN
  // Divide step, final value and single-cycle special cases
  logic [XLEN:0]       div_shift;
  logic [XLEN:0]       div_diff;
  logic                div_ge;
  logic [2*XLEN-1:0]   div_acc_next;
  logic [XLEN-1:0]     div_quo;
  logic [XLEN-1:0]     div_rem;
  logic [XLEN-1:0]     div_res;
  logic                div_zero;
  logic                div_ovf;
  logic [XLEN-1:0]     special_res;
`endif

  // Signedness, magnitudes and per-iteration datapath
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    if (f3[2]) begin
      a_signed = ~f3[0];
      b_signed = ~f3[0];
    end else begin
      a_signed = (f3[1:0] == 2'b01) || (f3[1:0] == 2'b10);
      b_signed = (f3[1:0] == 2'b01);
    end
    in_neg_a = a_signed & rs1[XLEN-1];
    in_neg_b = b_signed & rs2[XLEN-1];
    abs_a    = in_neg_a ? -rs1 : rs1;
    abs_b    = in_neg_b ? -rs2 : rs2;

    mul_acc_next = opb[0] ? (acc + mcand) : acc;
    mul_prod     = (neg_a ^ neg_b) ? -mul_acc_next : mul_acc_next;
    mul_res      = (op == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

`ifdef MULDIV_DIV_EN
    div_shift    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff     = div_shift - {1'b0, opb};
    div_ge       = ~div_diff[XLEN];
    div_acc_next = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                    acc[XLEN-2:0], div_ge};
    div_quo      = div_acc_next[XLEN-1:0];
    div_rem      = div_acc_next[2*XLEN-1:XLEN];
    div_res      = op[1] ? (neg_a ? -div_rem : div_rem)
                         : ((neg_a ^ neg_b) ? -div_quo : div_quo);

    div_zero     = (rs2 == '0);
    div_ovf      = ~f3[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    if (div_zero) special_res = f3[1] ? rs1 : '1;
    else          special_res = f3[1] ? '0 : rs1;
`endif
  end

  // Control FSM with registered outputs and iterative datapath
  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      op      <= '0;
      neg_a   <= 1'b0;
      neg_b   <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      opb     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      result  <= '0;
    end else if (abort) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done    <= 1'b0;
          illegal <= 1'b0;
          if (start) begin
            op    <= f3[1:0];
            neg_a <= in_neg_a;
            neg_b <= in_neg_b;
            cnt   <= '0;
            busy  <= 1'b1;
            if (!f3[2]) begin
              acc   <= '0;
              mcand <= {{XLEN{1'b0}}, abs_a};
              opb   <= abs_b;
              state <= S_MUL;
            end else begin
`ifdef MULDIV_DIV_EN
              if (div_zero || div_ovf) begin
                result <= special_res;
                done   <= 1'b1;
                state  <= S_FIN;
              end else begin
                acc   <= {{XLEN{1'b0}}, abs_a};
                opb   <= abs_b;
                state <= S_DIV;
              end
`else
              result  <= '0;
              done    <= 1'b1;
              illegal <= 1'b1;
              state   <= S_FIN;
`endif
            end
          end
        end
        S_MUL: begin
          acc   <= mul_acc_next;
          mcand <= mcand << 1;
          opb   <= opb >> 1;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            result <= mul_res;
            done   <= 1'b1;
            state  <= S_FIN;
          end
        end
`ifdef MULDIV_DIV_EN
        S_DIV: begin
          acc <= div_acc_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            result <= div_res;
            done   <= 1'b1;
            state  <= S_FIN;
          end
        end
`endif
        S_FIN: begin
          done    <= 1'b0;
          illegal <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (XLEN=32).
// Divide vectors apply when MULDIV_DIV_EN is defined; otherwise divide ops
// are expected to finish in one cycle with illegal set and result 0.
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [2:0]      f3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            abort;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            illegal;

  int n_checks = 0;
  int n_errors = 0;
  logic [XLEN-1:0] last_exp = '0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .f3      (f3),
    .rs1     (rs1),
    .rs2     (rs2),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, measure start-to-done latency, and check the completion
  // cycle plus the cycle after it. A start pulse with other operands is
  // injected at cycle 'poke' (0 = none) and must be ignored.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] exp_res, input int exp_lat,
                        input logic exp_ill, input int poke);
    int lat;
    int busy_lo;
    start = 1'b1; f3 = op; rs1 = a; rs2 = b;
    tick();
    start = 1'b0; f3 = ~op; rs1 = ~a; rs2 = ~b;
    lat = 1;
    busy_lo = 0;
    while (!done && lat < 200) begin
      if (!busy) busy_lo++;
      if (lat == poke) begin
        start = 1'b1; f3 = 3'b011; rs1 = '1; rs2 = '1;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, 64'(result), 64'(exp_res));
    check({tag, " illegal"}, 64'(illegal), 64'(exp_ill));
    check({tag, " busy low cycles"}, 64'(busy_lo), 64'(0));
    check({tag, " busy at done"}, 64'(busy), 64'(1));
    tick();
    check({tag, " done cleared"}, 64'(done), 64'(0));
    check({tag, " busy cleared"}, 64'(busy), 64'(0));
    check({tag, " result held"}, 64'(result), 64'(exp_res));
    last_exp = exp_res;
  endtask

  // Count done pulses over a window where none may appear
  task automatic expect_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done) seen++;
      tick();
    end
    check({tag, " no done"}, 64'(seen), 64'(0));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; f3 = '0; rs1 = '0; rs2 = '0;
    tick();
    tick();
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset illegal", 64'(illegal), 64'(0));
    check("reset result", 64'(result), 64'(0));
    reset = 1'b1;
    tick();

    // Multiply family
    run_op("MUL 7*-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b0, 0);
    run_op("MULH min*min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1'b0, 0);
    run_op("MULHU max*max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0, 0);
    run_op("MULHSU -1*2", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, 1'b0, 0);
    run_op("MULH -1*-1", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b0, 0);
    run_op("MUL start ignored", 3'b000, 32'd6, 32'd7, 32'd42, 33, 1'b0, 5);

`ifdef MULDIV_DIV_EN
    run_op("DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0, 0);
    run_op("REM -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0, 0);
    run_op("DIV 7/-2", 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1'b0, 0);
    run_op("REM 7/-2", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 1'b0, 0);
    run_op("DIVU 100/7", 3'b101, 32'd100, 32'd7, 32'd14, 33, 1'b0, 0);
    run_op("REMU 100/7", 3'b111, 32'd100, 32'd7, 32'd2, 33, 1'b0, 0);
    run_op("DIV 5/0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0, 0);
    run_op("REM 5/0", 3'b110, 32'd5, 32'd0, 32'd5, 1, 1'b0, 0);
    run_op("DIVU 5/0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0, 0);
    run_op("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0, 0);
    run_op("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0, 0);
    run_op("DIVU big", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 1'b0, 0);
    run_op("REMU big", 3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 1'b0, 0);
    run_op("DIVU max/3", 3'b101, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 33, 1'b0, 0);
`else
    run_op("DIVU disabled", 3'b101, 32'd100, 32'd7, 32'd0, 1, 1'b1, 0);
    run_op("REM disabled", 3'b110, 32'd5, 32'd0, 32'd0, 1, 1'b1, 0);
`endif
    run_op("MUL 6*7", 3'b000, 32'd6, 32'd7, 32'd42, 33, 1'b0, 0);

    // Abort at cycle 10 of an iterative op: no done, result unchanged
`ifdef MULDIV_DIV_EN
    start = 1'b1; f3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7;
`else
    start = 1'b1; f3 = 3'b011; rs1 = 32'd100; rs2 = 32'd7;
`endif
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    check("abort busy before", 64'(busy), 64'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort busy", 64'(busy), 64'(0));
    check("abort done", 64'(done), 64'(0));
    check("abort result", 64'(result), 64'(last_exp));
    expect_quiet("abort", 40);

    // Abort together with start in IDLE drops the start
    start = 1'b1; abort = 1'b1; f3 = 3'b000; rs1 = 32'd3; rs2 = 32'd3;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort+start busy", 64'(busy), 64'(0));
    expect_quiet("abort+start", 40);
    check("abort+start result", 64'(result), 64'(last_exp));

    // Reset asserted at cycle 20 of a MUL clears outputs immediately
    start = 1'b1; f3 = 3'b000; rs1 = 32'h1234; rs2 = 32'h10;
    tick();
    start = 1'b0;
    for (int i = 1; i < 20; i++) tick();
    check("pre-reset busy", 64'(busy), 64'(1));
    reset = 1'b0;
    #1;
    check("mid reset busy", 64'(busy), 64'(0));
    check("mid reset done", 64'(done), 64'(0));
    check("mid reset illegal", 64'(illegal), 64'(0));
    check("mid reset result", 64'(result), 64'(0));
    #2;
    reset = 1'b1;
    tick();
    expect_quiet("after reset", 40);
    run_op("MUL after reset", 3'b000, 32'h1234, 32'h10, 32'h0001_2340, 33, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
